draw_blocks_shaded: RTL and testbench
=====================================

# draw_blocks_shaded

Parametrised successor to the monochrome block painter. It walks every cell of the velocity field in raster order and reads each cell's 96-bit word (xn, yn, mag) from the synchronous field RAM. It quantises the magnitude to a DRAW_DATAW-bit colour and paints a BLOCK_SIZE×BLOCK_SIZE tile of that colour into the framebuffer, with an optional grid-line overlay. It sits between the field RAM (read port) and the framebuffer (write port) and supports abort and back-to-back frames.

## Interface
- DRAW_WIDTH, 640: framebuffer width in pixels
- DRAW_HEIGHT, 480: framebuffer height in pixels
- FIELD_WIDTH, 8: field cells per row
- FIELD_HEIGHT, 6: field rows
- FIELD_SIZE, FIELD_WIDTH*FIELD_HEIGHT: total cells
- FIELD_DATAW, 96: field word; xn [95:64], yn [63:32], mag [31:0] (unsigned)
- FIELD_ADDRW, $clog2(FIELD_SIZE): field address width
- BLOCK_SIZE, DRAW_WIDTH/FIELD_WIDTH: tile edge in pixels
- DRAW_DATAW, 4: colour bits per pixel
- DRAW_ADDRW, $clog2(DRAW_WIDTH*DRAW_HEIGHT): framebuffer address width
- MAG_SHIFT, 0: right shift applied to mag before saturation
- GRID_COLOR, all ones: colour of grid pixels

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle frame request; honoured only in IDLE
- abort  in  1  cancel current frame
- grid_en  in  1  grid overlay enable; sampled on accepted start
- busy  out  1  high from accepted start until DONE/abort
- done  out  1  one-cycle pulse at frame completion
- field_addr_write  out  FIELD_ADDRW  field RAM read address
- field_data_in  in  FIELD_DATAW  field RAM data, 1-cycle read latency
- draw_addr_write  out  DRAW_ADDRW  framebuffer write address
- draw_data_in  out  DRAW_DATAW  framebuffer write data
- draw_we  out  1  framebuffer write enable

## Operation
- States: IDLE → FETCH → WAIT → PAINT → (FETCH for the next cell | DONE) → IDLE.
- IDLE: start=1 latches grid_en, clears the cell counter and goes to FETCH. start is ignored in every other state.
- FETCH: field_addr_write = cell index. draw_we = 0.
- WAIT: the RAM is presenting data. On the WAIT→PAINT edge, latch colour = min(mag >> MAG_SHIFT, 2^DRAW_DATAW−1).
- PAINT: one pixel per cycle, row-major inside the tile (px 0..B−1, then py).
  - Address = (by·B + py)·DRAW_WIDTH + bx·B + px, where bx = cell mod FIELD_WIDTH and by = cell div FIELD_WIDTH.
  - Address is computed incrementally (row base += DRAW_WIDTH); no runtime multiplier.
  - Data = GRID_COLOR when grid latched and (px==0 or py==0); otherwise colour.
  - After pixel (B−1, B−1): last cell → DONE, else cell+1 → FETCH.
- DONE: done = 1 for one cycle, busy drops, return to IDLE.
- abort = 1 in any non-IDLE state: go to IDLE next edge, draw_we = 0, busy = 0, no done pulse. Abort takes priority over every other transition.
- xn and yn are ignored; they are reserved for the arrow painter.

## Timing
- Reset value of every output is 0. State = IDLE. All outputs are registered.
- Edge numbering: E0 is the edge that samples start.
  - E1: FETCH, field_addr_write = 0.
  - E2: WAIT.
  - From E3: draw_we = 1 for exactly B² consecutive cycles per cell.
- Each cell costs 2 + B² cycles. draw_we is low during that cell's FETCH and WAIT.
- done is high after edge E(FIELD_SIZE·(2+B²)+1). Default parameters: 307297.
- busy rises after E1 and falls with the done pulse.
- start on the same cycle as done's IDLE return is accepted on the next edge. Back-to-back frames have a 1-cycle gap.
- rst_n assertion mid-frame: immediate return to IDLE with all outputs 0. The partial frame is left as is.

## Test plan
Test parameters: FIELD 2×2, B=4, DRAW 8×8, DRAW_DATAW=4, MAG_SHIFT=0, GRID_COLOR=4'h8.

- Reset: hold rst_n=0 with start=1 → all outputs 0 and no draw_we. Release reset → still IDLE until a fresh start.
- Basic frame: mags {0, 5, 15, 100} → 64 writes.
  - Cell 0 covers addresses 0–3, 8–11, 16–19, 24–27.
  - Tile colours 0, 5, 15, 15 (last is saturated).
  - done pulses exactly after E73.
- Grid: same mags with grid_en=1 at start.
  - Address 0 and addresses 4–7 read 8.
  - Address 9 reads 0.
  - Address 45 (cell 3, px1, py1) reads 15.
- Shift/saturate: MAG_SHIFT=16 with mag 32'h0003_FFFF → 3; with mag 32'h00FF_0000 → 15.
- Abort: assert abort during cell 1 PAINT.
  - Next cycle: draw_we = 0, busy = 0, no done pulse.
  - A new start repaints from cell 0 with the correct timing.
- Start while busy: pulse start at E20 → ignored and done timing unchanged. A start on the done cycle → second frame with field_addr_write = 0 at the following FETCH.

Source files
------------

// File: rtl/draw_blocks_shaded.sv
// Raster-walks the velocity field, quantises each cell's magnitude to a colour
// and paints a BLOCK_SIZE x BLOCK_SIZE tile per cell, with optional grid lines.
module draw_blocks_shaded #(
  parameter int DRAW_WIDTH   = 640,
  parameter int DRAW_HEIGHT  = 480,
  parameter int FIELD_WIDTH  = 8,
  parameter int FIELD_HEIGHT = 6,
  parameter int FIELD_SIZE   = FIELD_WIDTH * FIELD_HEIGHT,
  parameter int FIELD_DATAW  = 96,
  parameter int FIELD_ADDRW  = $clog2(FIELD_SIZE),
  parameter int BLOCK_SIZE   = DRAW_WIDTH / FIELD_WIDTH,
  parameter int DRAW_DATAW   = 4,
  parameter int DRAW_ADDRW   = $clog2(DRAW_WIDTH * DRAW_HEIGHT),
  parameter int MAG_SHIFT    = 0,
  parameter logic [DRAW_DATAW-1:0] GRID_COLOR = '1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   grid_en,
  output logic                   busy,
  output logic                   done,
  output logic [FIELD_ADDRW-1:0] field_addr_write,
  input  logic [FIELD_DATAW-1:0] field_data_in,
  output logic [DRAW_ADDRW-1:0]  draw_addr_write,
  output logic [DRAW_DATAW-1:0]  draw_data_in,
  output logic                   draw_we
);

  localparam int PXW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int BXW = (FIELD_WIDTH > 1) ? $clog2(FIELD_WIDTH) : 1;

  localparam logic [PXW-1:0]         LP_B_LAST    = PXW'(BLOCK_SIZE - 1);
  localparam logic [BXW-1:0]         LP_BX_LAST   = BXW'(FIELD_WIDTH - 1);
  localparam logic [FIELD_ADDRW-1:0] LP_CELL_LAST = FIELD_ADDRW'(FIELD_SIZE - 1);
  localparam logic [DRAW_ADDRW-1:0]  LP_ROW_STEP  = DRAW_ADDRW'(DRAW_WIDTH);
  localparam logic [DRAW_ADDRW-1:0]  LP_TILE_STEP = DRAW_ADDRW'(BLOCK_SIZE * DRAW_WIDTH);
  localparam logic [DRAW_ADDRW-1:0]  LP_COL_STEP  = DRAW_ADDRW'(BLOCK_SIZE);
  localparam logic [31:0]            LP_CMAX      = 32'((1 << DRAW_DATAW) - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_PAINT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]             r_state;
  logic [FIELD_ADDRW-1:0] r_cell;
  logic [BXW-1:0]         r_bx;
  logic [DRAW_ADDRW-1:0]  r_tile_col;
  logic [DRAW_ADDRW-1:0]  r_tile_row;
  logic [DRAW_ADDRW-1:0]  r_row_base;
  logic [PXW-1:0]         r_px;
  logic [PXW-1:0]         r_py;
  logic                   r_grid;
  logic [DRAW_DATAW-1:0]  r_color;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_we;
  logic [FIELD_ADDRW-1:0] r_field_addr;
  logic [DRAW_ADDRW-1:0]  r_draw_addr;
  logic [DRAW_DATAW-1:0]  r_draw_data;

  logic [31:0]           w_mag;
  logic [DRAW_DATAW-1:0] w_quant;
  logic                  w_first;
  logic [DRAW_DATAW-1:0] w_color;
  logic [DRAW_DATAW-1:0] w_pix;
  logic                  w_unused;

  // xn/yn belong to the arrow painter
  assign w_unused = ^field_data_in[FIELD_DATAW-1:32];

  assign w_mag   = field_data_in[31:0] >> MAG_SHIFT;
  assign w_quant = (w_mag > LP_CMAX) ? '1 : w_mag[DRAW_DATAW-1:0];
  assign w_first = (r_px == '0) && (r_py == '0);
  // RAM data is only valid on the first pixel's edge; later pixels use the latched colour
  assign w_color = w_first ? w_quant : r_color;
  assign w_pix   = (r_grid && ((r_px == '0) || (r_py == '0))) ? GRID_COLOR : w_color;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cell       <= '0;
      r_bx         <= '0;
      r_tile_col   <= '0;
      r_tile_row   <= '0;
      r_row_base   <= '0;
      r_px         <= '0;
      r_py         <= '0;
      r_grid       <= 1'b0;
      r_color      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_we         <= 1'b0;
      r_field_addr <= '0;
      r_draw_addr  <= '0;
      r_draw_data  <= '0;
    end else if (abort && (r_state != S_IDLE)) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_we   <= 1'b0;
          if (start) begin
            r_grid     <= grid_en;
            r_cell     <= '0;
            r_bx       <= '0;
            r_tile_col <= '0;
            r_tile_row <= '0;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_busy       <= 1'b1;
          r_we         <= 1'b0;
          r_field_addr <= r_cell;
          r_row_base   <= r_tile_row + r_tile_col;
          r_px         <= '0;
          r_py         <= '0;
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          r_we    <= 1'b0;
          r_state <= S_PAINT;
        end
        S_PAINT: begin
          r_we        <= 1'b1;
          r_draw_addr <= r_row_base + DRAW_ADDRW'(r_px);
          r_draw_data <= w_pix;
          if (w_first) r_color <= w_quant;
          if (r_px == LP_B_LAST) begin
            r_px       <= '0;
            r_row_base <= r_row_base + LP_ROW_STEP;
            if (r_py == LP_B_LAST) begin
              if (r_cell == LP_CELL_LAST) begin
                r_state <= S_DONE;
              end else begin
                r_cell <= r_cell + FIELD_ADDRW'(1);
                if (r_bx == LP_BX_LAST) begin
                  r_bx       <= '0;
                  r_tile_col <= '0;
                  r_tile_row <= r_tile_row + LP_TILE_STEP;
                end else begin
                  r_bx       <= r_bx + BXW'(1);
                  r_tile_col <= r_tile_col + LP_COL_STEP;
                end
                r_state <= S_FETCH;
              end
            end else begin
              r_py <= r_py + PXW'(1);
            end
          end else begin
            r_px <= r_px + PXW'(1);
          end
        end
        S_DONE: begin
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign draw_we          = r_we;
  assign field_addr_write = r_field_addr;
  assign draw_addr_write  = r_draw_addr;
  assign draw_data_in     = r_draw_data;

endmodule

// File: tb/tb_draw_blocks_shaded.sv
// Directed bench for draw_blocks_shaded on a 2x2 field painted into an 8x8 framebuffer.
module tb_draw_blocks_shaded;

  localparam int FA = 2;
  localparam int DA = 6;
  localparam int DD = 4;
  localparam int FD = 96;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, s_start = 1'b0, abort = 1'b0, grid_en = 1'b0;
  logic busy, done, we, s_busy, s_done, s_we;
  logic [FA-1:0] faddr, s_faddr;
  logic [FD-1:0] fdata, s_fdata;
  logic [DA-1:0] daddr, s_daddr;
  logic [DD-1:0] ddata, s_ddata;

  logic [FD-1:0] mem [4];
  logic [FD-1:0] mem_s [4];
  logic [DD-1:0] fb [64];
  logic [DD-1:0] fb_s [64];
  logic [DD-1:0] fb_basic [64];
  logic [DD-1:0] fb_grid [64];

  int checks = 0;
  int failures = 0;
  int res_done, res_wr, res_first_we, res_busy_e0, res_busy_e1, res_faddr_e1;
  int res_abort_we, res_abort_busy, res_busy_done;

  typedef struct {
    bit grid;
    int addr;
    int exp;
  } vec_t;
  vec_t vecs [22];

  draw_blocks_shaded #(
    .DRAW_WIDTH(8), .DRAW_HEIGHT(8), .FIELD_WIDTH(2), .FIELD_HEIGHT(2),
    .BLOCK_SIZE(4), .DRAW_DATAW(4), .MAG_SHIFT(0), .GRID_COLOR(4'h8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .grid_en(grid_en),
    .busy(busy), .done(done), .field_addr_write(faddr), .field_data_in(fdata),
    .draw_addr_write(daddr), .draw_data_in(ddata), .draw_we(we)
  );

  draw_blocks_shaded #(
    .DRAW_WIDTH(8), .DRAW_HEIGHT(8), .FIELD_WIDTH(2), .FIELD_HEIGHT(2),
    .BLOCK_SIZE(4), .DRAW_DATAW(4), .MAG_SHIFT(16), .GRID_COLOR(4'h8)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(abort), .grid_en(grid_en),
    .busy(s_busy), .done(s_done), .field_addr_write(s_faddr), .field_data_in(s_fdata),
    .draw_addr_write(s_daddr), .draw_data_in(s_ddata), .draw_we(s_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    fdata   <= mem[faddr];
    s_fdata <= mem_s[s_faddr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_fb();
    for (int i = 0; i < 64; i++) begin
      fb[i]   = 4'h3;
      fb_s[i] = 4'h3;
    end
  endtask

  task automatic set_start(input bit sel, input bit v);
    if (sel) s_start = v;
    else start = v;
  endtask

  // Edge n of the loop is En, counted from the edge that samples start (E0).
  task automatic run_frame(input bit sel, input bit grid, input int extra_start,
                           input int abort_at);
    bit o_we, o_busy, o_done;
    int o_addr, o_data, o_faddr;
    res_done = -1; res_wr = 0; res_first_we = -1; res_busy_e1 = 0; res_faddr_e1 = -1;
    res_abort_we = -1; res_abort_busy = -1; res_busy_done = -1;
    grid_en = grid;
    set_start(sel, 1'b1);
    tick();
    set_start(sel, 1'b0);
    grid_en = 1'b0;
    res_busy_e0 = sel ? int'(s_busy) : int'(busy);
    for (int n = 1; n <= 150; n++) begin
      if (n == extra_start) set_start(sel, 1'b1);
      if (n == abort_at) abort = 1'b1;
      tick();
      set_start(sel, 1'b0);
      abort = 1'b0;
      o_we    = sel ? s_we : we;
      o_busy  = sel ? s_busy : busy;
      o_done  = sel ? s_done : done;
      o_addr  = sel ? int'(s_daddr) : int'(daddr);
      o_data  = sel ? int'(s_ddata) : int'(ddata);
      o_faddr = sel ? int'(s_faddr) : int'(faddr);
      if (n == 1) begin
        res_busy_e1  = int'(o_busy);
        res_faddr_e1 = o_faddr;
      end
      if (n == abort_at) begin
        res_abort_we   = int'(o_we);
        res_abort_busy = int'(o_busy);
      end
      if (o_we) begin
        if (sel) fb_s[o_addr] = DD'(o_data);
        else fb[o_addr] = DD'(o_data);
        res_wr++;
        if (res_first_we < 0) res_first_we = n;
      end
      if (o_done) begin
        res_done      = n;
        res_busy_done = int'(o_busy);
        break;
      end
    end
  endtask

  initial begin
    bit seen;
    vecs[0]  = '{0, 0, 0};   vecs[1]  = '{0, 3, 0};   vecs[2]  = '{0, 24, 0};
    vecs[3]  = '{0, 27, 0};  vecs[4]  = '{0, 4, 5};   vecs[5]  = '{0, 28, 5};
    vecs[6]  = '{0, 31, 5};  vecs[7]  = '{0, 32, 15}; vecs[8]  = '{0, 59, 15};
    vecs[9]  = '{0, 36, 15}; vecs[10] = '{0, 63, 15};
    vecs[11] = '{1, 0, 8};   vecs[12] = '{1, 4, 8};   vecs[13] = '{1, 5, 8};
    vecs[14] = '{1, 6, 8};   vecs[15] = '{1, 7, 8};   vecs[16] = '{1, 9, 0};
    vecs[17] = '{1, 45, 15}; vecs[18] = '{1, 12, 8};  vecs[19] = '{1, 13, 5};
    vecs[20] = '{1, 32, 8};  vecs[21] = '{1, 41, 15};

    mem[0]   = {32'hDEAD_BEEF, 32'h1234_5678, 32'd0};
    mem[1]   = {32'hFFFF_FFFF, 32'h0000_0001, 32'd5};
    mem[2]   = {32'h0000_0000, 32'hCAFE_F00D, 32'd15};
    mem[3]   = {32'h5555_AAAA, 32'h0F0F_0F0F, 32'd100};
    mem_s[0] = {32'h1111_1111, 32'h2222_2222, 32'h0003_FFFF};
    mem_s[1] = {32'h3333_3333, 32'h4444_4444, 32'h00FF_0000};
    mem_s[2] = '0;
    mem_s[3] = '0;
    clear_fb();

    rst_n = 1'b0; start = 1'b1; s_start = 1'b1;
    repeat (3) tick();
    check("reset_outputs", {busy, done, we, faddr, daddr, ddata}, 0);
    start = 1'b0; s_start = 1'b0;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (we || busy || done) seen = 1'b1;
    end
    check("idle_after_reset", seen, 0);

    run_frame(0, 0, -1, -1);
    check("basic_done_edge", res_done, 73);
    check("basic_writes", res_wr, 64);
    check("basic_first_we_edge", res_first_we, 3);
    check("basic_busy_e0", res_busy_e0, 0);
    check("basic_busy_e1", res_busy_e1, 1);
    check("basic_faddr_e1", res_faddr_e1, 0);
    check("basic_busy_at_done", res_busy_done, 0);
    tick();
    check("done_one_cycle", done, 0);
    fb_basic = fb;

    clear_fb();
    run_frame(0, 1, -1, -1);
    check("grid_done_edge", res_done, 73);
    fb_grid = fb;

    for (int i = 0; i < 22; i++) begin
      int got;
      got = vecs[i].grid ? int'(fb_grid[vecs[i].addr]) : int'(fb_basic[vecs[i].addr]);
      check($sformatf("%s_pix_%0d", vecs[i].grid ? "grid" : "basic", vecs[i].addr),
            got, vecs[i].exp);
    end

    run_frame(1, 0, -1, -1);
    check("shift_done_edge", res_done, 73);
    check("shift_sat_3", fb_s[0], 3);
    check("shift_sat_15", fb_s[4], 15);

    run_frame(0, 0, -1, 25);
    check("abort_we", res_abort_we, 0);
    check("abort_busy", res_abort_busy, 0);
    check("abort_no_done", res_done, -1);
    clear_fb();
    run_frame(0, 0, -1, -1);
    check("after_abort_done_edge", res_done, 73);
    check("after_abort_first_we", res_first_we, 3);
    check("after_abort_writes", res_wr, 64);
    check("after_abort_pix0", fb[0], 0);

    run_frame(0, 0, 20, -1);
    check("start_busy_done_edge", res_done, 73);
    check("start_busy_writes", res_wr, 64);

    check("pre_chain_faddr", faddr, 3);
    run_frame(0, 0, -1, -1);
    check("chain_busy_e0", res_busy_e0, 0);
    check("chain_faddr_e1", res_faddr_e1, 0);
    check("chain_busy_e1", res_busy_e1, 1);
    check("chain_done_edge", res_done, 73);

    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    rst_n = 1'b0;
    #1;
    check("midframe_reset", {busy, done, we, faddr, daddr, ddata}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
